// File: rtl/note_source_arbiter.sv
// Shares one tone generator between manual keys, song player and rec player.
// Priority is manual > song > rec; every hand-over inserts a silent gap.
module note_source_arbiter #(
  parameter int GAP_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] manual_keys,
  input  logic       song_req,
  input  logic       song_key_on,
  input  logic [3:0] song_key,
  input  logic       rec_req,
  input  logic       rec_key_on,
  input  logic [3:0] rec_key,
  output logic       key_on,
  output logic [3:0] key,
  output logic [1:0] owner,
  output logic       song_grant,
  output logic       rec_grant,
  output logic       gap_busy
);

  localparam int CW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAN,
    S_SONG,
    S_REC,
    S_GAP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_key_on;
  logic [3:0]    r_key;
  logic [1:0]    r_owner;
  logic          r_song_grant;
  logic          r_rec_grant;
  logic          r_gap_busy;

  logic          w_man_req;
  logic [3:0]    w_man_key;
  state_t        w_pick;
  state_t        w_nxt;
  logic          w_src_on;
  logic [3:0]    w_src_key;
  logic          w_hold;

  assign w_man_req = |manual_keys;

  // Lowest pressed key wins, so scan from the top down.
  always_comb begin
    w_man_key = '0;
    for (int i = 7; i >= 0; i--) begin
      if (manual_keys[i]) w_man_key = 4'(i);
    end
  end

  always_comb begin
    w_pick = S_IDLE;
    priority case (1'b1)
      w_man_req: w_pick = S_MAN;
      song_req:  w_pick = S_SONG;
      rec_req:   w_pick = S_REC;
      default:   w_pick = S_IDLE;
    endcase
  end

  always_comb begin
    w_nxt     = r_state;
    w_src_on  = 1'b0;
    w_src_key = '0;
    case (r_state)
      S_IDLE: w_nxt = w_pick;
      S_MAN: begin
        w_src_on  = w_man_req;
        w_src_key = w_man_key;
        if (!w_man_req) w_nxt = S_GAP;
      end
      S_SONG: begin
        w_src_on  = song_key_on;
        w_src_key = song_key;
        if (!song_req || (w_man_req && !song_key_on))
          w_nxt = S_GAP;
      end
      S_REC: begin
        w_src_on  = rec_key_on;
        w_src_key = rec_key;
        if (!rec_req
            || ((w_man_req || song_req) && !rec_key_on))
          w_nxt = S_GAP;
      end
      S_GAP: if (r_cnt == LAST) w_nxt = w_pick;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Pass-through only while the same owner keeps the generator.
  assign w_hold = (w_nxt == r_state)
               && (r_state inside {S_MAN, S_SONG, S_REC});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_key_on     <= 1'b0;
      r_key        <= '0;
      r_owner      <= 2'd0;
      r_song_grant <= 1'b0;
      r_rec_grant  <= 1'b0;
      r_gap_busy   <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_cnt    <= (r_state == S_GAP) ? r_cnt + 1'b1 : '0;
      r_key_on <= w_hold & w_src_on;
      if (w_hold && w_src_on) r_key <= w_src_key;
      case (w_nxt)
        S_MAN:   r_owner <= 2'd1;
        S_SONG:  r_owner <= 2'd2;
        S_REC:   r_owner <= 2'd3;
        default: r_owner <= 2'd0;
      endcase
      r_song_grant <= (w_nxt == S_SONG);
      r_rec_grant  <= (w_nxt == S_REC);
      r_gap_busy   <= (w_nxt == S_GAP);
    end
  end

  assign key_on     = r_key_on;
  assign key        = r_key;
  assign owner      = r_owner;
  assign song_grant = r_song_grant;
  assign rec_grant  = r_rec_grant;
  assign gap_busy   = r_gap_busy;

endmodule

// File: doc/note_source_arbiter.md
Name: note_source_arbiter

Overview:
Shares the single tone generator (key/key_on) between three note sources: live manual keys, the autoplay song player and the record-playback engine. Fixed priority manual > song > rec. Ownership changes only at note boundaries, and every hand-over inserts a silent gap so notes never splice. Sits between the three sources and the buzzer tone generator; grant outputs let the song and rec players pause while not owning the generator.

Parameters:
GAP_CYCLES, 1000000, silent cycles inserted on every ownership change (20 ms at 50 MHz); legal range >= 1.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
manual_keys  input  8  live key switches; bit n pressed = note n
song_req  input  1  song player has a valid song selected
song_key_on  input  1  song player note sounding
song_key  input  4  song player note index
rec_req  input  1  record-playback active
rec_key_on  input  1  rec note sounding
rec_key  input  4  rec note index
key_on  output  1  tone generator enable
key  output  4  tone generator note index
owner  output  2  0 none, 1 manual, 2 song, 3 rec
song_grant  output  1  song player owns generator
rec_grant  output  1  rec player owns generator
gap_busy  output  1  silent hand-over gap in progress

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, key_on=0, key=0, owner=0, both grants 0, gap_busy=0, gap counter 0. Reset mid-note cuts the note immediately.
- Request signals: man_req = |manual_keys; man_key = index of the lowest set bit of manual_keys (0..7, zero-extended to 4 bits). Requests for song and rec are song_req and rec_req.
- States: IDLE, OWN_MAN, OWN_SONG, OWN_REC, GAP. All outputs are registered.
- IDLE: pick the highest-priority active request and go directly to that owner state, with no gap. No request: stay in IDLE. Simultaneous requests resolve by priority.
- OWN_x, pass-through: on the next edge, key_on follows the source's key_on. For manual, key_on follows man_req. key loads the source key only while the source key_on=1. Otherwise key holds its last value. Latency from source change to output is 1 cycle.
- OWN_x, release: the owner's request drops -> GAP.
- OWN_x, preemption: a higher-priority request is present and the owner's key_on=0 (note boundary) -> GAP. Manual is never preempted. Song is never preempted by rec.
- A release and a preemption in the same cycle produce a single GAP.
- While the owner's note sounds, a higher-priority request waits; it is not latched. Preemption is decided from live requests.
- A change in manual_keys while in OWN_MAN updates key directly, with no gap.
- GAP: key_on=0, owner=0, grants 0, gap_busy=1. The counter clears on entry and increments each cycle. After exactly GAP_CYCLES cycles in GAP, arbitration is evaluated as in IDLE on live requests, and the block enters the winning owner state or IDLE. Requests that drop during GAP are ignored.
- Grants: song_grant=1 only in OWN_SONG; rec_grant=1 only in OWN_REC. owner encodes the current state (0 in IDLE and GAP). Grants and owner change on the same edge as the state.
- Counter width: $clog2(GAP_CYCLES+1). The counter does not wrap because it is cleared on every GAP entry.
- key values 0..15 pass through unmodified. No range check is done.

Test Plan:
(Bench uses GAP_CYCLES=4.)
1. Reset release, then song_req=1 with song_key_on=1 and song_key=5 -> next edge owner=2, song_grant=1; one cycle later key_on=1, key=5.
2. Song owns with song_key_on=1, then manual_keys=8'b0000_0100 -> no change while the note sounds. When song_key_on falls -> GAP for 4 cycles with key_on=0, gap_busy=1; then owner=1, key_on=1, key=2.
3. In IDLE, manual_keys=8'b1001_0000, song_req=1 and rec_req=1 in the same cycle -> owner=1, key=4. Then manual_keys=8'b1000_0000 -> key=7 with no gap.
4. Rec owns; rec_req drops in the same cycle that song_req rises -> a single 4-cycle GAP, then owner=2.
5. Song owns; song_req drops with no other requests -> GAP for 4 cycles, then IDLE with owner=0 and key held at its last value.
6. rst asserted low mid-GAP and mid-note -> outputs go to 0 asynchronously. After release -> IDLE, and the first grant comes with no gap.
